// File: rtl/conv_tap_scheduler_pkg.sv
// Shared constants, types and helpers for the time-multiplexed 32-tap
// convolution controller (conv_tap_scheduler and its MAC lane).
package conv_pkg;

  localparam int N_TAPS  = 32;
  localparam int DATA_W  = 4;
  localparam int ACC_W   = 13;
  localparam int LANES   = 4;
  localparam int N_STEPS = N_TAPS / LANES;
  localparam int IDX_W   = $clog2(N_STEPS);
  localparam int LANE_W  = $clog2(LANES);
  localparam int ADDR_W  = $clog2(N_TAPS);

  typedef logic [DATA_W-1:0] data_t;

  // Weights loaded at reset (and used as constants when loading is disabled).
  localparam data_t DEFAULT_W [N_TAPS] = '{
    4'd6,  4'd14, 4'd13, 4'd10, 4'd10, 4'd14, 4'd3,  4'd4,
    4'd0,  4'd6,  4'd7,  4'd9,  4'd11, 4'd12, 4'd6,  4'd3,
    4'd2,  4'd1,  4'd5,  4'd8,  4'd7,  4'd13, 4'd1,  4'd8,
    4'd7,  4'd12, 4'd13, 4'd10, 4'd10, 4'd9,  4'd7,  4'd7
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Unsigned DATA_W x DATA_W product, zero-extended to the accumulator width.
  function automatic logic [ACC_W-1:0] mul_ext(input data_t a, input data_t b);
    logic [2*DATA_W-1:0] p;
    p = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    return {{(ACC_W-2*DATA_W){1'b0}}, p};
  endfunction

endpackage

// File: rtl/conv_tap_scheduler_if.sv
// Handshake bundle for conv_tap_scheduler: IFM input channel and OFM
// result channel. master = upstream/downstream environment, slave = scheduler.
interface conv_tap_scheduler_if
  import conv_pkg::*;
();

  logic                     in_valid;
  logic                     in_ready;
  logic [N_TAPS*DATA_W-1:0] In_IFM;
  logic                     out_valid;
  logic                     out_ready;
  logic [ACC_W-1:0]         Out_OFM;

  modport master (
    output in_valid,
    output In_IFM,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  Out_OFM
  );

  modport slave (
    input  in_valid,
    input  In_IFM,
    input  out_ready,
    output in_ready,
    output out_valid,
    output Out_OFM
  );

endinterface

// File: rtl/conv_tap_scheduler_mac_lane.sv
// conv_mac_lane: combinational sum of LANES IFM x weight products.
// Each product is zero-extended to ACC_W before summing.
module conv_mac_lane
  import conv_pkg::*;
(
  input  logic [LANES*DATA_W-1:0] ifm,
  input  logic [LANES*DATA_W-1:0] wt,
  output logic [ACC_W-1:0]        psum
);

  // Accumulate the LANES products of this step.
  always_comb begin
    psum = {ACC_W{1'b0}};
    for (int j = 0; j < LANES; j++) begin
      psum = psum + mul_ext(ifm[j*DATA_W +: DATA_W], wt[j*DATA_W +: DATA_W]);
    end
  end

endmodule

// File: rtl/conv_tap_scheduler.sv
// conv_tap_scheduler: accepts one packed IFM vector, walks the taps LANES at
// a time through a single conv_mac_lane, then holds the result until the
// consumer takes it. FSM IDLE -> RUN -> DONE -> IDLE.
// Optional feature macro: CONV_WEIGHT_LOAD_EN adds wt_we/wt_addr/wt_data and
// writable weight registers; without it the weights are constants.
module conv_tap_scheduler
  import conv_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  conv_tap_scheduler_if.slave     bus,
  output logic                    busy
`ifdef CONV_WEIGHT_LOAD_EN
  ,
  input  logic                    wt_we,
  input  logic [ADDR_W-1:0]       wt_addr,
  input  data_t                   wt_data
`endif
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_STEPS - 1);

  state_t                    state_r;
  state_t                    state_s;
  logic [IDX_W-1:0]          idx_r;
  logic [ACC_W-1:0]          acc_r;
  logic [ACC_W-1:0]          acc_next_s;
  logic [ACC_W-1:0]          ofm_r;
  logic                      out_valid_r;
  data_t                     ifm_r [N_TAPS];
  logic [LANES*DATA_W-1:0]   ifm_lane_s;
  logic [LANES*DATA_W-1:0]   wt_lane_s;
  logic [ACC_W-1:0]          psum_s;
  logic                      accept_s;

  assign accept_s = (state_r == IDLE) && bus.in_valid;

`ifdef CONV_WEIGHT_LOAD_EN
  data_t                     wt_r [N_TAPS];
  // When a write and an accept share an edge, the overwritten weight is kept
  // here so the accepted vector still sees the old value.
  logic                      shadow_vld_r;
  logic [ADDR_W-1:0]         shadow_addr_r;
  data_t                     shadow_data_r;

  // Weight registers: writable only in IDLE, reload defaults on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wt_r          <= DEFAULT_W;
      shadow_vld_r  <= 1'b0;
      shadow_addr_r <= {ADDR_W{1'b0}};
      shadow_data_r <= {DATA_W{1'b0}};
    end else if (state_r == IDLE) begin
      if (wt_we) begin
        wt_r[wt_addr] <= wt_data;
      end
      if (bus.in_valid) begin
        shadow_vld_r  <= wt_we;
        shadow_addr_r <= wt_addr;
        shadow_data_r <= wt_r[wt_addr];
      end
    end
  end
`endif

  // Select the IFM and weight values for the taps handled at this step.
  always_comb begin : lane_sel_p
    logic [ADDR_W-1:0] tap;
    tap        = {ADDR_W{1'b0}};
    ifm_lane_s = {(LANES*DATA_W){1'b0}};
    wt_lane_s  = {(LANES*DATA_W){1'b0}};
    for (int j = 0; j < LANES; j++) begin
      tap = {idx_r, LANE_W'(j)};
      ifm_lane_s[j*DATA_W +: DATA_W] = ifm_r[tap];
`ifdef CONV_WEIGHT_LOAD_EN
      if (shadow_vld_r && (shadow_addr_r == tap)) begin
        wt_lane_s[j*DATA_W +: DATA_W] = shadow_data_r;
      end else begin
        wt_lane_s[j*DATA_W +: DATA_W] = wt_r[tap];
      end
`else
      wt_lane_s[j*DATA_W +: DATA_W] = DEFAULT_W[tap];
`endif
    end
  end

  conv_mac_lane u_mac (
    .ifm  (ifm_lane_s),
    .wt   (wt_lane_s),
    .psum (psum_s)
  );

  assign acc_next_s = acc_r + psum_s;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) state_s = RUN;
        else              state_s = IDLE;
      end
      RUN: begin
        if (idx_r == IDX_LAST) state_s = DONE;
        else                   state_s = RUN;
      end
      DONE: begin
        if (bus.out_ready) state_s = IDLE;
        else               state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // FSM outputs decoded from the state register.
  always_comb begin
    bus.in_ready = 1'b0;
    busy         = 1'b1;
    case (state_r)
      IDLE:    begin bus.in_ready = 1'b1; busy = 1'b0; end
      RUN:     begin bus.in_ready = 1'b0; busy = 1'b1; end
      DONE:    begin bus.in_ready = 1'b0; busy = 1'b1; end
      default: begin bus.in_ready = 1'b0; busy = 1'b1; end
    endcase
  end

  // Datapath: IFM capture, step counter, accumulator and result register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_r       <= {IDX_W{1'b0}};
      acc_r       <= {ACC_W{1'b0}};
      ofm_r       <= {ACC_W{1'b0}};
      out_valid_r <= 1'b0;
      for (int i = 0; i < N_TAPS; i++) begin
        ifm_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            for (int i = 0; i < N_TAPS; i++) begin
              ifm_r[i] <= bus.In_IFM[i*DATA_W +: DATA_W];
            end
            acc_r <= {ACC_W{1'b0}};
            idx_r <= {IDX_W{1'b0}};
          end
        end
        RUN: begin
          acc_r <= acc_next_s;
          idx_r <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
          if (idx_r == IDX_LAST) begin
            ofm_r       <= acc_next_s;
            out_valid_r <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.Out_OFM   = ofm_r;

endmodule
